roi_scan_driver: RTL

- Self-contained stimulus and capture engine for the serial ROI harness (`di`/`stb` in, `do` out, DIN_N/DOUT_N shift registers).
- Sits directly upstream and downstream of the harness top:
  - generates pseudo-random DIN_N-bit vectors and shifts them serially into `di`;
  - pulses `stb` to load each vector and capture the ROI output;
  - compresses the returned `do` stream into a 32-bit MISR signature.
- Lets a fuzzer bitstream be exercised on hardware and compared against a simulated golden signature.

---
 rtl/roi_scan_driver.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/roi_scan_driver.sv
// roi_scan_driver: LFSR stimulus generator and MISR capture engine for the serial ROI harness.
// Latency: a run lasts ITER*(L+1) + L+1 + DOUT_N + 1 cycles after start; all outputs are flop Q.
// Backpressure: none; the harness consumes one di bit and produces one do bit every cycle.
//
// Ports:
//   clk        rising-edge clock shared with the harness
//   rst_n      asynchronous active-low reset; aborts any run
//   start      begin a run (only honoured in IDLE)
//   di, stb    serial data and load/capture strobe towards the harness
//   do_in      serial data returning from the harness
//   busy       high from the first SHIFT cycle through the last DRAIN cycle
//   done       one-cycle pulse after the last DRAIN cycle
//   signature  32-bit MISR over the captured do_in bits; held until the next start
//   nsamples   number of do_in bits folded into signature
module roi_scan_driver #(
  parameter int          DIN_N  = 256,
  parameter int          DOUT_N = 256,
  parameter int          ITER   = 16,
  parameter logic [31:0] SEED   = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        di,
  output logic        stb,
  input  logic        do_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] signature,
  output logic [15:0] nsamples
);

  localparam int          L         = (DIN_N > DOUT_N) ? DIN_N : DOUT_N;
  localparam int          CW        = $clog2(L + 1);
  localparam int          MW        = $clog2(ITER + 2);
  // An all-zero LFSR would lock up, so a zero seed falls back to 1.
  localparam logic [31:0] SEED_EFF  = (SEED == 32'd0) ? 32'd1 : SEED;
  localparam logic [31:0] MISR_POLY = 32'h04C1_1DB7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_STROBE,
    S_FLUSH,
    S_FSTROBE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [MW-1:0]   m, m_nxt;
  logic [31:0]     lfsr, lfsr_nxt;
  logic [31:0]     sig_nxt;
  logic [15:0]     ns_nxt;
  logic            sample;
  logic            lfsr_fb;

  // Recurrence for x^32+x^22+x^2+x+1 with the oldest bit in lfsr[0].
  assign lfsr_fb = lfsr[22] ^ lfsr[2] ^ lfsr[1] ^ lfsr[0];

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    m_nxt     = m;
    lfsr_nxt  = lfsr;
    sig_nxt   = signature;
    ns_nxt    = nsamples;

    // The harness output register is valid for the first DOUT_N cycles after
    // a strobe; strobe 1 only returns the pre-load ROI state, so it is skipped.
    sample = ((state == S_SHIFT) || (state == S_FLUSH) || (state == S_DRAIN)) &&
             (cnt < CW'(DOUT_N)) && (m >= MW'(2));

    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_SHIFT;
          cnt_nxt   = '0;
          m_nxt     = '0;
          lfsr_nxt  = SEED_EFF;
          sig_nxt   = '0;
          ns_nxt    = '0;
        end
      end
      S_SHIFT: begin
        lfsr_nxt = {lfsr_fb, lfsr[31:1]};
        if (cnt == CW'(L - 1)) begin
          state_nxt = S_STROBE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      S_STROBE: begin
        m_nxt     = m + MW'(1);
        cnt_nxt   = '0;
        state_nxt = (m == MW'(ITER - 1)) ? S_FLUSH : S_SHIFT;
      end
      S_FLUSH: begin
        if (cnt == CW'(L - 1)) begin
          state_nxt = S_FSTROBE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      S_FSTROBE: begin
        m_nxt     = m + MW'(1);
        cnt_nxt   = '0;
        state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (cnt == CW'(DOUT_N - 1)) begin
          state_nxt = S_DONE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    if (sample) begin
      sig_nxt = {signature[30:0], 1'b0} ^ (signature[31] ? MISR_POLY : 32'd0) ^ {31'd0, do_in};
      ns_nxt  = nsamples + 16'd1;
    end
  end

  // Outputs are registered from the next-state decode so that each output is
  // a flop Q that lines up with the state occupied during the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      m         <= '0;
      lfsr      <= SEED_EFF;
      di        <= 1'b0;
      stb       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      signature <= '0;
      nsamples  <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      m         <= m_nxt;
      lfsr      <= lfsr_nxt;
      di        <= (state_nxt == S_SHIFT) ? lfsr_nxt[0] : 1'b0;
      stb       <= (state_nxt == S_STROBE) || (state_nxt == S_FSTROBE);
      busy      <= (state_nxt == S_SHIFT) || (state_nxt == S_STROBE) ||
                   (state_nxt == S_FLUSH) || (state_nxt == S_FSTROBE) ||
                   (state_nxt == S_DRAIN);
      done      <= (state_nxt == S_DONE);
      signature <= sig_nxt;
      nsamples  <= ns_nxt;
    end
  end

endmodule
